// File: rtl/decode_pkg.sv
// decode_pkg: shared types, opcodes and helpers for the decode stage.
package decode_pkg;
    localparam int XLEN = 32;
    localparam logic [1:0] RES_SRC_MEM = 2'b01;
    localparam logic [1:0] RES_SRC_PC4 = 2'b10;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;
    localparam logic [3:0] ALU_SUB    = 4'b1000;
    localparam logic [3:0] ALU_PASS_B = 4'b1111;

    typedef struct packed {
        logic            valid;
        logic            illegal;
        logic            reg_write;
        logic [1:0]      result_src;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic [3:0]      alu_control;
        logic            alu_src;
        logic [2:0]      funct3;
        logic            jalr;
        logic            op1_pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
    } de_bundle_t;

    function automatic logic reg_ok(input logic [4:0] idx, input int count);
        return int'(idx) < count;
    endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: decode inputs, writeback port and execute-side outputs of decode_stage.
interface decode_stage_if #(parameter int DATA_WIDTH = 32, parameter int PERF_W = 16);
    import decode_pkg::*;
    logic                  valid_d;
    logic [31:0]           instr_d;
    logic [DATA_WIDTH-1:0] pc_d;
    logic                  hold_e;
    logic                  flush_e;
    logic                  reg_write_w;
    logic [4:0]            rd_w;
    logic [DATA_WIDTH-1:0] result_w;
    de_bundle_t            de_e;
    logic                  stall_fd;
    logic [DATA_WIDTH-1:0] a0;
    logic [PERF_W-1:0]     bubble_cnt;
    modport master (output valid_d, instr_d, pc_d, hold_e, flush_e, reg_write_w, rd_w, result_w,
                    input de_e, stall_fd, a0, bubble_cnt);
    modport slave (input valid_d, instr_d, pc_d, hold_e, flush_e, reg_write_w, rd_w, result_w,
                   output de_e, stall_fd, a0, bubble_cnt);
endinterface

// File: rtl/control_unit.sv
// control_unit: RV32I main decoder producing control fields and source-register usage.
module control_unit import decode_pkg::*; (
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic       mem_write,
    output logic       jump,
    output logic       branch,
    output logic [3:0] alu_control,
    output logic       alu_src,
    output logic [2:0] imm_src,
    output logic       jalr,
    output logic       op1_pc,
    output logic       rs1_used,
    output logic       rs2_used
);
    always_comb begin
        {reg_write, result_src, mem_write, jump, branch, alu_control, alu_src, imm_src, jalr,
         op1_pc, rs1_used, rs2_used} = '0;
        case (op)
            OP_LOAD:   begin reg_write = 1'b1; result_src = RES_SRC_MEM; alu_src = 1'b1; rs1_used = 1'b1; end
            OP_STORE:  begin mem_write = 1'b1; alu_src = 1'b1; imm_src = IMM_S; rs1_used = 1'b1; rs2_used = 1'b1; end
            OP_REG:    begin reg_write = 1'b1; alu_control = {funct7b5, funct3}; rs1_used = 1'b1; rs2_used = 1'b1; end
            // only srai carries funct7[5] among the immediate ALU ops
            OP_IMM:    begin reg_write = 1'b1; alu_src = 1'b1; alu_control = {funct7b5 & (funct3 == 3'b101), funct3}; rs1_used = 1'b1; end
            OP_BRANCH: begin branch = 1'b1; imm_src = IMM_B; alu_control = ALU_SUB; rs1_used = 1'b1; rs2_used = 1'b1; end
            OP_JAL:    begin reg_write = 1'b1; jump = 1'b1; result_src = RES_SRC_PC4; imm_src = IMM_J; end
            OP_JALR:   begin reg_write = 1'b1; jump = 1'b1; jalr = 1'b1; result_src = RES_SRC_PC4; alu_src = 1'b1; rs1_used = 1'b1; end
            OP_LUI:    begin reg_write = 1'b1; alu_src = 1'b1; imm_src = IMM_U; alu_control = ALU_PASS_B; end
            OP_AUIPC:  begin reg_write = 1'b1; alu_src = 1'b1; imm_src = IMM_U; op1_pc = 1'b1; end
            default:   ;
        endcase
    end
endmodule

// File: rtl/reg_file_wf.sv
// reg_file_wf: REG_COUNT-deep register file with write-first bypass and an x10 tap.
module reg_file_wf import decode_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [4:0]            wa,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [4:0]            ra1,
    input  logic [4:0]            ra2,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    output logic [DATA_WIDTH-1:0] a0
);
    localparam int IW = $clog2(REG_COUNT);
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic                  wr_en;
    // x0 is never written, so regs[0] stays zero and needs no read special case
    assign wr_en = we && wa != 5'd0 && reg_ok(wa, REG_COUNT);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        else if (wr_en) regs[wa[IW-1:0]] <= wd;
    assign rd1 = (wr_en && wa == ra1) ? wd : reg_ok(ra1, REG_COUNT) ? regs[ra1[IW-1:0]] : '0;
    assign rd2 = (wr_en && wa == ra2) ? wd : reg_ok(ra2, REG_COUNT) ? regs[ra2[IW-1:0]] : '0;
    assign a0  = regs[10];
endmodule

// File: rtl/sign_extend.sv
// sign_extend: builds the sign-extended immediate for I/S/B/U/J formats.
module sign_extend import decode_pkg::*; (
    input  logic [31:7]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm_ext
);
    always_comb
        imm_ext = imm_src == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                  imm_src == IMM_B ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
                  imm_src == IMM_U ? {instr[31:12], 12'b0} :
                  imm_src == IMM_J ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
                                     {{20{instr[31]}}, instr[31:20]};
endmodule

// File: rtl/decode_stage.sv
// decode_stage: decode, register read, load-use detection and the D/E pipeline register.
module decode_stage import decode_pkg::*; #(
    parameter int DATA_WIDTH = XLEN,
    parameter int REG_COUNT  = 32,
    parameter int PERF_W     = 16
) (
    input logic           clk,
    input logic           rst_n,
    decode_stage_if.slave bus
);
    logic [4:0]            rs1, rs2, rd;
    logic                  reg_write, mem_write, jump, branch, alu_src, jalr, op1_pc;
    logic                  rs1_used, rs2_used, illegal, hz;
    logic [1:0]            result_src;
    logic [3:0]            alu_control;
    logic [2:0]            imm_src;
    logic [XLEN-1:0]       imm_ext;
    logic [DATA_WIDTH-1:0] rd1, rd2;
    logic [PERF_W-1:0]     cnt;
    de_bundle_t            dec, de_q;

    assign rs1 = bus.instr_d[19:15];
    assign rs2 = bus.instr_d[24:20];
    assign rd  = bus.instr_d[11:7];

    control_unit cu (.op(bus.instr_d[6:0]), .funct3(bus.instr_d[14:12]), .funct7b5(bus.instr_d[30]),
                     .reg_write, .result_src, .mem_write, .jump, .branch, .alu_control, .alu_src,
                     .imm_src, .jalr, .op1_pc, .rs1_used, .rs2_used);
    sign_extend se (.instr(bus.instr_d[31:7]), .imm_src, .imm_ext);
    reg_file_wf #(.DATA_WIDTH(DATA_WIDTH), .REG_COUNT(REG_COUNT)) rf (
        .clk, .rst_n, .we(bus.reg_write_w), .wa(bus.rd_w), .wd(bus.result_w),
        .ra1(rs1), .ra2(rs2), .rd1, .rd2, .a0(bus.a0));

    assign illegal = !reg_ok(rd, REG_COUNT) | (rs1_used & !reg_ok(rs1, REG_COUNT)) |
                     (rs2_used & !reg_ok(rs2, REG_COUNT));
    assign hz = bus.valid_d & de_q.valid & (de_q.result_src == RES_SRC_MEM) & (de_q.rd != 5'd0) &
                ((rs1_used & rs1 == de_q.rd) | (rs2_used & rs2 == de_q.rd));

    // illegal instructions still travel to E, but with every side effect stripped
    always_comb
        dec = '{valid: bus.valid_d, illegal: illegal, reg_write: reg_write & ~illegal,
                result_src: result_src, mem_write: mem_write & ~illegal, jump: jump & ~illegal,
                branch: branch & ~illegal, alu_control: alu_control, alu_src: alu_src,
                funct3: bus.instr_d[14:12], jalr: jalr, op1_pc: op1_pc, rd1: rd1, rd2: rd2,
                imm_ext: imm_ext, pc: bus.pc_d, rd: rd, rs1: rs1, rs2: rs2};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            de_q <= '0;
            cnt  <= '0;
        end else if (!bus.hold_e) begin
            de_q <= (bus.flush_e || hz) ? '0 : dec;
            if (hz && !bus.flush_e && cnt != '1) cnt <= cnt + 1'b1;
        end

    assign bus.de_e       = de_q;
    assign bus.stall_fd   = bus.hold_e | (hz & ~bus.flush_e);
    assign bus.bubble_cnt = cnt;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage in its RV32E configuration with a 2-bit bubble counter.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    decode_stage_if #(.DATA_WIDTH(32), .PERF_W(2)) bus ();
    decode_stage #(.DATA_WIDTH(32), .REG_COUNT(16), .PERF_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk)
        assert (!(rst_n && bus.hold_e && bus.flush_e)) else $error("FAIL protocol: flush_e asserted while hold_e");

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins);
        bus.valid_d = 1'b1;
        bus.instr_d = ins;
        bus.pc_d    = bus.pc_d + 32'd4;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm,
                                          input logic [2:0] f3, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_IMM  = 7'b0010011;

    task automatic load_use_pair();
        drive(enc_i(5'd7, 5'd1, 12'd0, 3'b010, OPC_LOAD));
        tick();
        drive(enc_r(5'd8, 5'd7, 5'd2));
        tick();
        tick();
    endtask

    initial begin
        bus.valid_d = 0; bus.instr_d = 0; bus.pc_d = 32'h100; bus.hold_e = 0; bus.flush_e = 0;
        bus.reg_write_w = 0; bus.rd_w = 0; bus.result_w = 0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_bundle_zero", {63'b0, |bus.de_e}, 64'd0);
        chk("rst_bubble_cnt", bus.bubble_cnt, 0);
        chk("rst_a0", bus.a0, 0);
        chk("rst_stall", bus.stall_fd, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // write-first bypass: x5 written while add x6,x5,x5 decodes
        bus.reg_write_w = 1; bus.rd_w = 5'd5; bus.result_w = 32'h1234;
        drive(enc_r(5'd6, 5'd5, 5'd5));
        #1 chk("bypass_stall", bus.stall_fd, 0);
        tick();
        chk("bypass_rd1", bus.de_e.rd1, 32'h1234);
        chk("bypass_rd2", bus.de_e.rd2, 32'h1234);
        chk("bypass_valid", bus.de_e.valid, 1);
        chk("bypass_rd", bus.de_e.rd, 6);
        bus.rd_w = 5'd10; bus.result_w = 32'hA0A0;
        #1 chk("a0_not_bypassed", bus.a0, 0);
        tick();
        chk("a0_written", bus.a0, 32'hA0A0);
        chk("stored_rd1", bus.de_e.rd1, 32'h1234);
        bus.reg_write_w = 0;

        // load-use: lw x7 then add x8,x7,x2
        drive(enc_i(5'd7, 5'd1, 12'd0, 3'b010, OPC_LOAD));
        tick();
        chk("lw_result_src", bus.de_e.result_src, 2'b01);
        drive(enc_r(5'd8, 5'd7, 5'd2));
        #1 chk("lu_stall", bus.stall_fd, 1);
        tick();
        chk("lu_bubble_valid", bus.de_e.valid, 0);
        chk("lu_bubble_regwrite", bus.de_e.reg_write, 0);
        chk("lu_cnt", bus.bubble_cnt, 1);
        #1 chk("lu_stall_released", bus.stall_fd, 0);
        tick();
        chk("lu_add_valid", bus.de_e.valid, 1);
        chk("lu_add_rd", bus.de_e.rd, 8);

        // no hazard: rs=x0, unused rs2 field matching, lw to x0
        drive(enc_i(5'd7, 5'd1, 12'd0, 3'b010, OPC_LOAD));
        tick();
        drive(enc_r(5'd8, 5'd0, 5'd0));
        #1 chk("nohz_x0_stall", bus.stall_fd, 0);
        tick();
        drive(enc_i(5'd7, 5'd1, 12'd0, 3'b010, OPC_LOAD));
        tick();
        drive(enc_i(5'd9, 5'd1, 12'd7, 3'b000, OPC_IMM));
        #1 chk("nohz_unused_rs2_stall", bus.stall_fd, 0);
        tick();
        chk("addi_imm", bus.de_e.imm_ext, 7);
        chk("addi_valid", bus.de_e.valid, 1);
        drive(enc_i(5'd0, 5'd1, 12'd0, 3'b010, OPC_LOAD));
        tick();
        drive(enc_r(5'd8, 5'd0, 5'd0));
        #1 chk("nohz_lw_x0_stall", bus.stall_fd, 0);
        tick();
        chk("nohz_cnt", bus.bubble_cnt, 1);

        // RV32E register range
        drive(enc_i(5'd20, 5'd1, 12'd1, 3'b000, OPC_IMM));
        tick();
        chk("illegal_flag", bus.de_e.illegal, 1);
        chk("illegal_regwrite", bus.de_e.reg_write, 0);
        bus.reg_write_w = 1; bus.rd_w = 5'd20; bus.result_w = 32'hFFFF;
        drive(enc_r(5'd9, 5'd20, 5'd0));
        tick();
        chk("x20_bypass_zero", bus.de_e.rd1, 0);
        bus.reg_write_w = 0;
        tick();
        chk("x20_read_zero", bus.de_e.rd1, 0);
        bus.reg_write_w = 1; bus.rd_w = 5'd15; bus.result_w = 32'h55;
        drive(enc_r(5'd9, 5'd15, 5'd0));
        tick();
        chk("x15_legal", bus.de_e.illegal, 0);
        chk("x15_rd1", bus.de_e.rd1, 32'h55);
        bus.reg_write_w = 0;

        // hold during a load-use pair
        drive(enc_i(5'd7, 5'd1, 12'd0, 3'b010, OPC_LOAD));
        tick();
        drive(enc_r(5'd8, 5'd7, 5'd2));
        bus.hold_e = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_stall", bus.stall_fd, 1);
            tick();
            chk("hold_frozen_rd", bus.de_e.rd, 7);
            chk("hold_frozen_src", bus.de_e.result_src, 2'b01);
            chk("hold_cnt", bus.bubble_cnt, 1);
        end
        bus.hold_e = 0;
        #1 chk("post_hold_stall", bus.stall_fd, 1);
        tick();
        chk("post_hold_bubble", bus.de_e.valid, 0);
        chk("post_hold_cnt", bus.bubble_cnt, 2);
        tick();
        chk("post_hold_add_rd", bus.de_e.rd, 8);

        // flush during a hazard
        drive(enc_i(5'd7, 5'd1, 12'd0, 3'b010, OPC_LOAD));
        tick();
        drive(enc_r(5'd8, 5'd7, 5'd2));
        bus.flush_e = 1;
        #1 chk("flush_stall", bus.stall_fd, 0);
        tick();
        chk("flush_bubble", bus.de_e.valid, 0);
        chk("flush_cnt", bus.bubble_cnt, 2);
        bus.flush_e = 0;
        tick();
        chk("after_flush_valid", bus.de_e.valid, 1);

        // saturation of the 2-bit counter
        load_use_pair();
        chk("sat_cnt_3", bus.bubble_cnt, 3);
        load_use_pair();
        chk("sat_cnt_hold", bus.bubble_cnt, 3);

        // asynchronous reset mid-stall
        drive(enc_i(5'd7, 5'd1, 12'd0, 3'b010, OPC_LOAD));
        tick();
        drive(enc_r(5'd8, 5'd7, 5'd2));
        #1 chk("pre_reset_stall", bus.stall_fd, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.de_e.valid, 0);
        chk("midrst_cnt", bus.bubble_cnt, 0);
        chk("midrst_a0", bus.a0, 0);
        chk("midrst_stall", bus.stall_fd, 0);
        rst_n = 1'b1;
        tick();
        chk("after_rst_valid", bus.de_e.valid, 1);
        chk("after_rst_rd", bus.de_e.rd, 8);
        chk("after_rst_cnt", bus.bubble_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised successor to the decode stage of the 5-stage RV32I core. Combines instruction decode, a register file of configurable depth with write-first bypass, load-use hazard detection, and the D/E pipeline register with valid, hold and flush, so the execute stage receives one registered bundle. Reduced-register configurations (RV32E) are supported, and a saturating bubble counter is provided for performance analysis.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width
- REG_COUNT, 32, architectural registers; legal values 16 or 32
- PERF_W, 16, bubble counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- valid_d  in  1  instr_d holds a real instruction
- instr_d  in  32  instruction in decode
- pc_d  in  DATA_WIDTH  PC of instr_d
- hold_e  in  1  downstream stall: freeze the D/E register
- flush_e  in  1  kill the decode instruction (taken branch or jump in execute)
- reg_write_w  in  1  writeback enable
- rd_w  in  5  writeback destination
- result_w  in  DATA_WIDTH  writeback data
- de_e  out  de_bundle_t  registered execute bundle
- stall_fd  out  1  hold the PC and the F/D register this cycle
- a0  out  DATA_WIDTH  current value of x10
- bubble_cnt  out  PERF_W  load-use bubbles inserted

Fixed decision: one clock; reset is asynchronous and active-low, using ports clk and rst_n.

## Operation
- Decode: control_unit and sign_extend are reused unchanged and produce the control fields, imm_ext, funct3 and the rs1_used / rs2_used flags.
- Register file, stored state:
  - x0 reads as 0. A write occurs on the clock edge when reg_write_w=1, rd_w!=0 and rd_w<REG_COUNT.
  - Reads are write-first. If reg_write_w=1, rd_w!=0 and rd_w equals rs1 or rs2, the matching read returns result_w in the same cycle.
  - Indices at or above REG_COUNT read 0 and are never written.
- Illegal-register check: a decode instruction is illegal when rd, or a used rs1/rs2, is at or above REG_COUNT. Illegal instructions enter E with illegal=1 and with reg_write, mem_write, jump and branch forced to 0.
- Load-use hazard: hz = valid_d & de_e.valid & (de_e.result_src==2'b01) & (de_e.rd!=0) & ((rs1_used & rs1==de_e.rd) | (rs2_used & rs2==de_e.rd)).
- D/E register update, in priority order:
  1. hold_e: register unchanged; stall_fd=1.
  2. flush_e: load a bubble; stall_fd=0.
  3. hz: load a bubble; stall_fd=1; bubble_cnt increments.
  4. Otherwise: load the decoded bundle with valid=valid_d.
- Bubble definition: valid=0 and reg_write=mem_write=jump=branch=0. Data fields are don't-care; the RTL drives them to 0.
- bubble_cnt saturates at all ones and does not wrap.
- stall_fd is combinational: hold_e | (hz & ~flush_e).
- a0 is the stored x10 and is not bypassed.
- Protocol violation: flush_e=1 while hold_e=1. The bench asserts on it; the RTL gives hold_e priority.

## Timing
- Bundle latency: one cycle from decode inputs to de_e.
- Bypass: write-first read is zero-latency (same cycle).
- rst_n low, taking effect immediately without waiting for a clock edge:
  - every de_e field = 0 (valid=0)
  - all registers = 0
  - bubble_cnt = 0
- After reset release: stall_fd = 0 while hold_e=0.
- Reset mid-stall: pending bubbles are discarded; the first cycle after release is a normal load.
- Load-use: exactly one bubble per hazard. The dependent instruction enters E in the next cycle, when de_e.result_src is no longer 01 for that rd.
- Hazard and writeback same cycle, same register: the write happens and the bubble is still inserted.
- Hazard plus hold_e: hold wins. The hazard is re-evaluated once hold_e drops; bubble_cnt does not count hold cycles.

## Structure
- Package decode_pkg holds:
  - de_bundle_t (packed): valid, illegal, reg_write, result_src[1:0], mem_write, jump, branch, alu_control[3:0], alu_src, funct3[2:0], jalr, op1_pc, rd1, rd2, imm_ext, pc, rd, rs1, rs2
  - RES_SRC_MEM = 2'b01
  - the REG_COUNT legality check
- Natural sub-module: reg_file_wf. It holds the parametrised REG_COUNT file with the write-first bypass and the a0 tap. control_unit and sign_extend are instantiated as-is.

## Test plan
- Reset, then write x5=0x1234 via writeback; decode add x6,x5,x5 in the same cycle -> de_e.rd1=rd2=0x1234 on the next edge (bypass), stall_fd=0.
- lw x7,0(x1) followed by add x8,x7,x2 -> stall_fd=1 for one cycle, one bubble (valid=0), bubble_cnt=1, add appears in E one cycle later.
- lw x7 followed by add x8,x0,x0 and by lw x0 -> no stall; rd=0 and unused-rs cases never trigger the hazard.
- REG_COUNT=16: addi x20,x1,1 -> de_e.illegal=1, reg_write=0; a write to x20 is ignored and a read of x20 returns 0.
- hold_e high for 3 cycles during a load-use pair -> de_e frozen, stall_fd=1, bubble_cnt unchanged; then one bubble and bubble_cnt+1. Separately, flush_e during a hazard -> bubble, stall_fd=0, no count.
- PERF_W=2, 5 hazards -> bubble_cnt stops at 3. Asserting rst_n low mid-stall clears de_e.valid and bubble_cnt immediately.
